// File: rtl/cpu_top_verify.sv
// Single-cycle RV32I integer core with an external instruction port and a
// combinational debug read port into the register file. Loads, stores,
// fences and system instructions retire as no-ops.
module cpu_top_verify #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra3,
  output logic [31:0] rd3,
  input  logic [31:0] imem_out,
  output logic [31:0] imem_addr
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_f3_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

  logic [31:0] pc;
  logic [31:0] xreg [1:31];

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_b;
  logic [31:0] imm_j;

  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] pc_plus4;

  logic [31:0] alu_b;
  logic        alu_alt;
  logic [31:0] alu_y;
  logic        br_taken;

  logic        wb_en;
  logic [31:0] wb_data;
  logic [31:0] next_pc;

  // Instruction field and immediate extraction
  assign opcode   = imem_out[6:0];
  assign rd       = imem_out[11:7];
  assign funct3   = imem_out[14:12];
  assign rs1      = imem_out[19:15];
  assign rs2      = imem_out[24:20];
  assign funct7b5 = imem_out[30];

  assign imm_i = {{20{imem_out[31]}}, imem_out[31:20]};
  assign imm_u = {imem_out[31:12], 12'b0};
  assign imm_b = {{19{imem_out[31]}}, imem_out[31], imem_out[7],
                  imem_out[30:25], imem_out[11:8], 1'b0};
  assign imm_j = {{11{imem_out[31]}}, imem_out[31], imem_out[19:12],
                  imem_out[20], imem_out[30:21], 1'b0};

  // Register reads: x0 is hard-wired to zero
  assign rs1_val = (rs1 == 5'd0) ? '0 : xreg[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : xreg[rs2];
  assign rd3     = (ra3 == 5'd0) ? '0 : xreg[ra3];

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // ALU operand selection; SUB only exists for register-register ops
  always_comb begin
    alu_b   = rs2_val;
    alu_alt = funct7b5;
    if (opcode != OPC_OP) begin
      alu_b   = imm_i;
      alu_alt = (funct3 == F3_SR) && funct7b5;
    end
  end

  // Integer ALU shared by OP and OP-IMM
  always_comb begin
    alu_y = '0;
    case (funct3)
      F3_ADD:  alu_y = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      F3_SLL:  alu_y = rs1_val << alu_b[4:0];
      F3_SLT:  alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      F3_SLTU: alu_y = {31'b0, rs1_val < alu_b};
      F3_XOR:  alu_y = rs1_val ^ alu_b;
      F3_SR:   alu_y = alu_alt ? 32'($signed(rs1_val) >>> alu_b[4:0])
                               : (rs1_val >> alu_b[4:0]);
      F3_OR:   alu_y = rs1_val | alu_b;
      F3_AND:  alu_y = rs1_val & alu_b;
      default: alu_y = '0;
    endcase
  end

  // Branch condition evaluation
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Writeback data and next-PC selection per opcode
  always_comb begin
    wb_en   = 1'b0;
    wb_data = '0;
    next_pc = pc_plus4;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        wb_en   = 1'b1;
        wb_data = alu_y;
      end
      OPC_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OPC_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc + imm_u;
      end
      OPC_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = (rs1_val + imm_i) & 32'hffff_fffe;
      end
      OPC_BRANCH: begin
        if (br_taken) next_pc = pc + imm_b;
      end
      default: begin
        wb_en = 1'b0;
      end
    endcase
  end

  // PC and register file update; reset overrides any writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      for (int unsigned i = 1; i < 32; i++) xreg[i] <= '0;
    end else begin
      pc <= next_pc;
      if (wb_en && (rd != 5'd0)) xreg[rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_cpu_top_verify.sv
// Scoreboard bench for cpu_top_verify: directed program fragments followed by
// random instructions, checked against an architectural reference model.
module tb_cpu_top_verify;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra3 = 5'd0;
  logic [31:0] rd3;
  logic [31:0] imem_out = 32'h0000_0013;
  logic [31:0] imem_addr;

  cpu_top_verify #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .ra3(ra3),
    .rd3(rd3),
    .imem_out(imem_out),
    .imem_addr(imem_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  ra;
    logic [31:0] val;
    int          id;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;
  int step    = 0;

  // Architectural state of the reference model
  logic [31:0] m_pc;
  logic [31:0] m_x [32];

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt,
                                          input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb_;
    sa  = int'(a);
    sb_ = int'(b);
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < sb_) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit ref_branch(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) <  int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input logic [31:0] ins, input bit r);
    logic [31:0] a, b, ii, ib, ij, iu, res, nxt;
    logic [4:0]  rdn;
    logic [2:0]  f3;
    bit          wr;
    if (r) begin
      m_pc = RST_PC;
      for (int i = 0; i < 32; i++) m_x[i] = '0;
      return;
    end
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    rdn = ins[11:7];
    f3  = ins[14:12];
    ii  = 32'(int'(ins) >>> 20);
    iu  = ins & 32'hffff_f000;
    ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = m_pc + 32'd4;
    res = '0;
    wr  = 1'b0;
    case (ins[6:0])
      7'h33: begin wr = 1'b1; res = ref_alu(f3, ins[30], a, b); end
      7'h13: begin wr = 1'b1; res = ref_alu(f3, (f3 == 3'd5) && ins[30], a, ii); end
      7'h37: begin wr = 1'b1; res = iu; end
      7'h17: begin wr = 1'b1; res = m_pc + iu; end
      7'h6f: begin wr = 1'b1; res = m_pc + 32'd4; nxt = m_pc + ij; end
      7'h67: begin wr = 1'b1; res = m_pc + 32'd4; nxt = (a + ii) & ~32'd1; end
      7'h63: if (ref_branch(f3, a, b)) nxt = m_pc + ib;
      default: wr = 1'b0;
    endcase
    if (wr && rdn != 5'd0) m_x[rdn] = res;
    m_pc = nxt;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [4:0] ra, input bit r);
    exp_t e;
    @(negedge clk);
    rst      = r;
    imem_out = ins;
    ra3      = ra;
    model_step(ins, r);
    e.pc  = m_pc;
    e.ra  = ra;
    e.val = m_x[ra];
    e.id  = step;
    step++;
    sb.push_back(e);
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic bit supported(input logic [6:0] op);
    return op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17 ||
           op == 7'h6f || op == 7'h67 || op == 7'h63;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [11:0] imm;
    logic [2:0]  br_f3 [6];
    logic [6:0]  nops [4];
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    nops  = '{7'h03, 7'h23, 7'h0f, 7'h73};
    rd  = rnd_reg();
    rs1 = rnd_reg();
    rs2 = rnd_reg();
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0, 1: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      2, 3: begin
        if (f3 == 3'd1) imm[11:5] = 7'h00;
        if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return {imm, rs1, f3, rd, 7'h13};
      end
      4: return {20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17};
      5: return {20'($urandom), rd, 7'h6f};
      6: return {imm, rs1, 3'd0, rd, 7'h67};
      7, 8: return {7'($urandom), rs2, rs1, br_f3[$urandom_range(0, 5)], 5'($urandom), 7'h63};
      default: begin
        if ($urandom_range(0, 1) == 1) op = nops[$urandom_range(0, 3)];
        else begin
          op = 7'($urandom);
          while (supported(op)) op = 7'($urandom);
        end
        return {25'($urandom), op};
      end
    endcase
  endfunction

  // Monitor: one scoreboard entry is retired per rising edge once stimulus runs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_total++;
        if (imem_addr === e.pc) n_pass++;
        else $display("FAIL pc step%0d: got %h want %h", e.id, imem_addr, e.pc);
        n_total++;
        if (rd3 === e.val) n_pass++;
        else $display("FAIL rd3 step%0d x%0d: got %h want %h", e.id, e.ra, rd3, e.val);
      end
    end
  end

  // Stimulus
  initial begin
    for (int i = 1; i < 32; i++) issue(32'h0000_0013, 5'(i), 1'b1);
    issue(32'h0000_0013, 5'd0, 1'b0);
    issue(32'h0000_0013, 5'd0, 1'b0);

    issue(32'h0000_0093, 5'd1, 1'b0);
    issue(32'h0000_0113, 5'd2, 1'b0);
    issue(32'h0020_e1b3, 5'd3, 1'b0);
    issue(32'hfff0_0093, 5'd1, 1'b0);
    issue(32'h0000_0113, 5'd2, 1'b0);
    issue(32'h0020_e1b3, 5'd3, 1'b0);
    issue(32'hfff0_0093, 5'd1, 1'b0);
    issue(32'h0ff0_0113, 5'd2, 1'b0);
    issue(32'h0020_e1b3, 5'd3, 1'b0);
    issue(32'h0000_0013, 5'd2, 1'b0);
    issue(32'h0020_81b3, 5'd3, 1'b0);
    issue(32'h4020_81b3, 5'd3, 1'b0);
    issue(32'hfff0_0013, 5'd0, 1'b0);
    issue(32'h1234_52b7, 5'd5, 1'b0);

    issue(32'h0000_0013, 5'd5, 1'b1);
    issue(32'h0000_0463, 5'd0, 1'b0);
    issue(32'h0100_00ef, 5'd1, 1'b0);
    issue(32'h0000_1463, 5'd1, 1'b0);

    issue(32'hfff0_0093, 5'd1, 1'b0);
    issue(32'h0ff0_0113, 5'd2, 1'b0);
    issue(32'h0020_e1b3, 5'd3, 1'b1);
    for (int i = 1; i < 32; i++) issue(32'h0000_0013, 5'(i), 1'b0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      logic [4:0]  ra;
      ins = rnd_instr();
      ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : ins[11:7];
      issue(ins, ra, $urandom_range(0, 149) == 0);
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
